// File: rtl/ram_rd_burst_ctrl_if.sv
// Command, RAM-issue and return-strobe bundle between ram_rd_burst_ctrl and its neighbours.
// slave = the controller's view; master = the sequencer/RAM-side view driving it.
interface ram_rd_burst_ctrl_if #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_LEN  = 8
);
  logic                 i_start;
  logic [SIZE_ADDR-1:0] i_base_addr;
  logic [SIZE_LEN-1:0]  i_len;
  logic                 i_stall;
  logic                 i_valid;
  logic                 o_ready;
  logic                 o_busy;
  logic                 o_rd_en;
  logic [SIZE_ADDR-1:0] o_rd_addr;
  logic                 o_done;
  logic                 o_err;

  modport slave (
    input  i_start, i_base_addr, i_len, i_stall, i_valid,
    output o_ready, o_busy, o_rd_en, o_rd_addr, o_done, o_err
  );

  modport master (
    output i_start, i_base_addr, i_len, i_stall, i_valid,
    input  o_ready, o_busy, o_rd_en, o_rd_addr, o_done, o_err
  );
endinterface

// File: rtl/ram_rd_burst_ctrl.sv
// Burst read sequencer: issues one RAM read per word, caps reads in flight, pulses o_done when all words return.
// Optional watchdog abort when RD_TIMEOUT_EN is defined (limit TIMEOUT_CYC cycles without a return).
module ram_rd_burst_ctrl #(
  parameter int SIZE_ADDR   = 8,
  parameter int SIZE_LEN    = 8,
  parameter int MAX_OUTST   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  ram_rd_burst_ctrl_if.slave     bus
);

  localparam int                 OUTST_W   = $clog2(MAX_OUTST + 1);
  localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  generate
    if (MAX_OUTST < 1 || MAX_OUTST > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("ram_rd_burst_ctrl: MAX_OUTST must be 1..15 and TIMEOUT_CYC >= 1");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [SIZE_ADDR-1:0] base_q, base_d;
  logic [SIZE_LEN-1:0]  len_q, len_d;
  logic [SIZE_LEN-1:0]  issued_q, issued_d;
  logic [SIZE_LEN-1:0]  returned_q, returned_d;
  logic [OUTST_W-1:0]   outst_q, outst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 in_burst;
  logic                 rd_en;
  logic                 ret_ok;
  logic [SIZE_ADDR-1:0] rd_addr;

`ifdef RD_TIMEOUT_EN
  localparam int                WDOG_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_run;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_en      = 1'b0;

    in_burst = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    // A strobe with nothing in flight cannot belong to this burst, so it is dropped.
    ret_ok   = in_burst && bus.i_valid && (outst_q != '0);
    if (state_q == ST_ISSUE) begin
      rd_en = !bus.i_stall && (outst_q < OUTST_MAX);
    end
    rd_addr = base_q + SIZE_ADDR'(issued_q);

    if (rd_en) begin
      issued_d = issued_q + SIZE_LEN'(1);
    end
    if (ret_ok) begin
      returned_d = returned_q + SIZE_LEN'(1);
    end
    if (rd_en && !ret_ok) begin
      outst_d = outst_q + OUTST_W'(1);
    end else if (!rd_en && ret_ok) begin
      outst_d = outst_q - OUTST_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len == '0) begin
            err_d = 1'b1;
          end else begin
            base_d     = bus.i_base_addr;
            len_d      = bus.i_len;
            issued_d   = '0;
            returned_d = '0;
            outst_d    = '0;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (rd_en && (issued_q == len_q - SIZE_LEN'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (returned_d == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef RD_TIMEOUT_EN
    // Watchdog counts consecutive return-free cycles while reads are in flight.
    wdog_run = in_burst && !bus.i_valid && (outst_q != '0);
    wdog_d   = '0;
    if (wdog_run) begin
      if (wdog_q == WDOG_LIM) begin
        state_d    = ST_IDLE;
        err_d      = 1'b1;
        issued_d   = '0;
        returned_d = '0;
        outst_d    = '0;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
`endif

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RD_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef RD_TIMEOUT_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign bus.o_ready   = (state_q == ST_IDLE);
  assign bus.o_busy    = in_burst;
  assign bus.o_rd_en   = rd_en;
  // Address is forced to zero outside issue cycles so idle/reset outputs stay deterministic.
  assign bus.o_rd_addr = rd_en ? rd_addr : '0;
  assign bus.o_done    = done_q;
  assign bus.o_err     = err_q;

endmodule
